// File: rtl/load_store_unit.sv
// Load/store unit between the core's execute stage and data memory: lane select, sign/zero extension,
// byte enables, alignment checks and a wait-state handshake with timeout. One request in flight at a time.
module load_store_unit #(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WAIT   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [3:0]            mem_byteen,
  output logic [31:0]           mem_writedata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_readdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  ofs_q;
  logic [7:0]  wait_cnt;

  logic        legal;
  logic [3:0]  byteen_c;
  logic [31:0] wdata_c;
  logic [31:0] ext_c;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        timeout;

  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  assign req_ready  = (state == IDLE);
  assign mem_req    = (state == ACCESS);
  assign resp_valid = (state == RESP);
  assign timeout    = (wait_cnt == 8'(MAX_WAIT - 1));

  // Request decode: legality, lane enables and replicated store data
  always_comb begin
    legal    = 1'b0;
    byteen_c = 4'b0000;
    wdata_c  = 32'h0;
    case (req_funct3[1:0])
      2'd0: begin
        byteen_c = 4'b0001 << req_addr[1:0];
        wdata_c  = {4{req_wdata[7:0]}};
        legal    = 1'b1;
      end
      2'd1: begin
        byteen_c = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c  = {2{req_wdata[15:0]}};
        legal    = !req_addr[0];
      end
      2'd2: begin
        byteen_c = 4'b1111;
        wdata_c  = req_wdata;
        legal    = (req_addr[1:0] == 2'b00);
      end
      default: legal = 1'b0;
    endcase
    // Unsigned variants exist only for byte and half-word loads
    if (req_funct3[2] && (req_we || req_funct3[1]))
      legal = 1'b0;
    if (!req_we)
      wdata_c = 32'h0;
  end

  always_comb begin
    byte_sel = mem_readdata[8*ofs_q +: 8];
    half_sel = ofs_q[1] ? mem_readdata[31:16] : mem_readdata[15:0];
    case (funct3_q)
      3'd0:    ext_c = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    ext_c = {{16{half_sel[15]}}, half_sel};
      3'd4:    ext_c = {24'h0, byte_sel};
      3'd5:    ext_c = {16'h0, half_sel};
      default: ext_c = mem_readdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = legal ? ACCESS : RESP;
      ACCESS:  if (mem_ack || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q          <= 1'b0;
      funct3_q      <= 3'd0;
      ofs_q         <= 2'd0;
      wait_cnt      <= 8'd0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_byteen    <= 4'b0000;
      mem_writedata <= 32'h0;
      resp_err      <= 1'b0;
      resp_rdata    <= 32'h0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q          <= req_we;
          funct3_q      <= req_funct3;
          ofs_q         <= req_addr[1:0];
          wait_cnt      <= 8'd0;
          mem_write     <= req_we;
          mem_address   <= req_addr[ADDR_WIDTH+1:2];
          mem_byteen    <= byteen_c;
          mem_writedata <= wdata_c;
          resp_err      <= !legal;
          resp_rdata    <= 32'h0;
        end
        // Ack in the final permitted cycle takes priority over the timeout
        ACCESS: begin
          if (mem_ack) begin
            if (!we_q) resp_rdata <= ext_c;
          end else if (timeout) begin
            resp_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
